// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The fetch stage drives the master side. The memory drives the slave side.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_rdy, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_data);
endinterface

// File: rtl/fetch_stage.sv
// Purpose: owns the PC, fetches instruction words and registers them into IF/ID.
// Latency: one cycle from imem_rdy to instr/pcs; sustains one instruction per cycle.
// Backpressure: stall freezes all state and withdraws imem_req; imem_rdy=0 inserts bubbles.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [15:0]          pc_branch,
    fetch_stage_if.master        imem,
    output logic [15:0]          instr,
    output logic [15:0]          pcs,
    output logic                 instr_valid,
    output logic                 halted,
    output logic [15:0]          pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      stateQ, stateD;
    logic [15:0] pcD, instrD, pcsD;
    logic        validD, haltedD;
    logic [15:0] pcPlus2;

    assign pcPlus2        = pc + 16'd2;
    assign imem.imem_addr = pc;
    // rst gates the request so memory sees nothing while the core is held in reset.
    assign imem.imem_req  = rst && !stall && (stateQ != S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ      <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            pcs         <= 16'h0000;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            stateQ      <= stateD;
            pc          <= pcD;
            instr       <= instrD;
            pcs         <= pcsD;
            instr_valid <= validD;
            halted      <= haltedD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        pcD     = pc;
        instrD  = instr;
        pcsD    = pcs;
        validD  = instr_valid;
        haltedD = halted;
        if (!stall) begin
            case (stateQ)
                S_FETCH, S_WAIT: begin
                    // Redirect wins over any same-cycle response, including a wrong-path HLT.
                    if (branch_taken) begin
                        pcD    = pc_branch;
                        validD = 1'b0;
                        stateD = S_FETCH;
                    end else if (imem.imem_rdy) begin
                        instrD = imem.imem_data;
                        pcsD   = pcPlus2;
                        validD = 1'b1;
                        if (imem.imem_data[15:12] == HALT_OPCODE) begin
                            haltedD = 1'b1;
                            stateD  = S_HALT;
                        end else begin
                            pcD    = pcPlus2;
                            stateD = S_FETCH;
                        end
                    end else begin
                        validD = 1'b0;
                        stateD = S_WAIT;
                    end
                end
                S_HALT: begin
                    validD = 1'b0;
                end
                default: begin
                    stateD = S_FETCH;
                    validD = 1'b0;
                end
            endcase
        end
    end

endmodule
